bcd_stopwatch_counter: RTL and testbench
========================================

BCD_STOPWATCH_COUNTER -- requirements
Module: bcd_stopwatch_counter

Interface
REQ-001 The block SHALL have one clock, msclk; reset is synchronous and active-high, port reset.
REQ-002 Parameter TICK_DIV, default 10: number of msclk cycles per count step; legal range 2..65535.
REQ-003 Port msclk  in  1  system clock; all state updates on the rising edge.
REQ-004 Port reset  in  1  synchronous active-high reset.
REQ-005 Port start_stop  in  1  single-cycle pulse that toggles run/pause.
REQ-006 Port clear  in  1  single-cycle pulse that zeroes the count and returns to IDLE.
REQ-007 Port load  in  1  single-cycle pulse that loads load_val and returns to IDLE.
REQ-008 Port load_val  in  16  preset value as four BCD nibbles: [15:12] thousands down to [3:0] ones.
REQ-009 Port dir  in  1  count direction: 0 = up, 1 = down; sampled on every tick.
REQ-010 Port one, ten, hun, thoud  out  4 each  registered BCD digits that feed the four-digit display driver.
REQ-011 Port running  out  1  high while in RUN.
REQ-012 Port done  out  1  high while in DONE.

Function
REQ-013 The state machine SHALL have four states: IDLE, RUN, PAUSE, DONE.
- IDLE -> RUN on start_stop.
- RUN -> PAUSE on start_stop.
- PAUSE -> RUN on start_stop.
- RUN -> DONE on terminal count.
- DONE ignores start_stop.
REQ-014 Input priority within one cycle SHALL be reset > clear > load > start_stop; a lower-priority input is ignored in that cycle.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick is the RUN cycle with prescaler == TICK_DIV-1, after which the prescaler wraps to 0.
REQ-016 The prescaler SHALL be zeroed on IDLE->RUN, clear and load, and SHALL hold its value through PAUSE.
REQ-017 On a tick the digits SHALL step by one in BCD, with the new value visible on the same edge.
- The first step after leaving IDLE SHALL occur exactly TICK_DIV cycles after the start_stop cycle.
REQ-018 Up-count: each digit SHALL wrap 9 -> 0 and carry into the next digit.
- A tick at 9999 SHALL hold 9999 and enter DONE.
REQ-019 Down-count: each digit SHALL wrap 0 -> 9 and borrow from the next digit.
- A tick at 0000 SHALL hold 0000 and enter DONE.
REQ-020 Terminal detection SHALL use the dir value sampled at the tick.
- Entering RUN already at the terminal value for the current dir SHALL reach DONE on the first tick, with the digits unchanged.
REQ-021 A load_val nibble above 9 SHALL be clamped to 9 on load.
REQ-022 clear and load SHALL take effect from any state, including mid-RUN and in DONE.
REQ-023 Digit outputs SHALL never hold a non-BCD value.
REQ-024 running and done SHALL be registered and decoded directly from state, with no extra latency.

Reset
REQ-025 On reset the block SHALL set state = IDLE, prescaler = 0, all four digits = 0, running = 0 and done = 0.
REQ-026 Reset SHALL override every other input in the same cycle, including mid-RUN.

Structure
REQ-027 A shared package SHALL hold the state enum, a 4-bit BCD digit type, and the constants BCD_MAX = 9 and NUM_DIGITS = 4.
REQ-028 The block SHALL contain one sub-module, bcd_digit: a single digit counter with en, dir, load and clear inputs, carry/borrow out, and terminal flag.
- bcd_stopwatch_counter SHALL instantiate four bcd_digit instances in a ripple chain.

Verification
REQ-029 The bench SHALL cover the following directed scenarios, all with TICK_DIV = 4:
- Reset, start_stop, dir = 0, run 40 cycles -> digits 0010; running = 1.
- Load 16'h0999, dir = 0, start, run 4 cycles -> 1000, with the carry rippling across three digits in one tick.
- Load 16'h0002, dir = 1, start, run 12 cycles -> sequence 0001, 0000, then DONE = 1 with the value held at 0000; a further start_stop is ignored.
- Start, pause after 6 cycles, wait 20 cycles, resume -> next step occurs 2 cycles after resume; value unchanged during PAUSE.
- Assert clear and load together in RUN -> digits 0000, IDLE; then load 16'hAB3F -> digits 9939.
- Assert reset and start_stop together mid-RUN at 0123 -> next cycle IDLE, 0000, running = 0.

Source files
------------

// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch counter.
package bcd_stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX    = 4'd9;
  localparam int   NUM_DIGITS = 4;

  // Preset nibbles above 9 saturate so a digit never leaves the BCD range.
  function automatic bcd_t clamp_bcd(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_if.sv
// Control pulses, preset value and display/status outputs of the stopwatch.
interface bcd_stopwatch_counter_if;
  import bcd_stopwatch_counter_pkg::*;

  logic        start_stop;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        dir;
  bcd_t        one;
  bcd_t        ten;
  bcd_t        hun;
  bcd_t        thoud;
  logic        running;
  logic        done;

  modport master (
    output start_stop, clear, load, load_val, dir,
    input  one, ten, hun, thoud, running, done
  );

  modport slave (
    input  start_stop, clear, load, load_val, dir,
    output one, ten, hun, thoud, running, done
  );

endinterface

// File: rtl/bcd_stopwatch_counter_digit.sv
// One BCD digit: up/down step with wrap, clear, clamped load, carry/borrow out.
module bcd_digit
  import bcd_stopwatch_counter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic dir_i,
  input  logic clear_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  output bcd_t q_o,
  output logic co_o,
  output logic term_o
);

  bcd_t digit_q, digit_d;

  // At the wrap point for the current direction the digit is terminal.
  assign term_o = dir_i ? (digit_q == 4'd0) : (digit_q == BCD_MAX);
  assign co_o   = en_i && !clear_i && !load_i && term_o;
  assign q_o    = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = clamp_bcd(load_val_i);
    end else if (en_i) begin
      if (dir_i) digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      else       digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch: run/pause FSM, tick prescaler and rippled digit chain.
module bcd_stopwatch_counter
  import bcd_stopwatch_counter_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic                    msclk,
  input  logic                    reset,
  bcd_stopwatch_counter_if.slave  bus
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_e                  state_q;
  logic [15:0]             presc_q;
  logic                    running_q;
  logic                    done_q;
  logic                    tick;
  logic                    all_term;
  logic [NUM_DIGITS-1:0]   en;
  logic [NUM_DIGITS-1:0]   co;
  logic [NUM_DIGITS-1:0]   term;
  bcd_t                    dq [NUM_DIGITS];
  logic                    unused_top_carry;

  assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST) && !bus.clear && !bus.load;
  assign all_term = &term;
  // A tick at the terminal value freezes the digits; only the FSM reacts.
  assign en[0]    = tick && !all_term;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i      (msclk),
      .rst_i      (reset),
      .en_i       (en[g]),
      .dir_i      (bus.dir),
      .clear_i    (bus.clear),
      .load_i     (bus.load),
      .load_val_i (bus.load_val[4*g +: 4]),
      .q_o        (dq[g]),
      .co_o       (co[g]),
      .term_o     (term[g])
    );
    if (g < NUM_DIGITS - 1) begin : g_ripple
      assign en[g+1] = co[g];
    end
  end

  assign unused_top_carry = co[NUM_DIGITS-1];

  assign bus.one     = dq[0];
  assign bus.ten     = dq[1];
  assign bus.hun     = dq[2];
  assign bus.thoud   = dq[3];
  assign bus.running = running_q;
  assign bus.done    = done_q;

  always_ff @(posedge msclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.clear || bus.load) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_stop) begin
            state_q   <= ST_RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // The prescaler keeps counting in the cycle that pauses, so a resume
          // continues from where the phase left off.
          presc_q <= tick ? '0 : presc_q + 16'd1;
          if (tick && all_term) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.start_stop) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (bus.start_stop) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_DONE: ;
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed and randomized checks of the stopwatch against a decimal-value model.
module tb_bcd_stopwatch_counter;

  localparam int TDIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic msclk = 1'b0;
  logic reset = 1'b1;

  bcd_stopwatch_counter_if bus ();

  bcd_stopwatch_counter #(.TICK_DIV(TDIV)) dut (
    .msclk (msclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 msclk = ~msclk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_st  = M_IDLE;
  int m_val = 0;
  int m_pre = 0;

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int dut_val();
    return int'(bus.thoud) * 1000 + int'(bus.hun) * 100 + int'(bus.ten) * 10 + int'(bus.one);
  endfunction

  function automatic int preset_val(input logic [15:0] v);
    int r = 0;
    int scale = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'((v >> (4 * i)) & 16'hF);
      if (d > 9) d = 9;
      r += d * scale;
      scale *= 10;
    end
    return r;
  endfunction

  // Model of one clock edge, evaluated from the inputs present at that edge.
  task automatic model_step();
    if (reset) begin
      m_st = M_IDLE; m_val = 0; m_pre = 0;
    end else if (bus.clear) begin
      m_st = M_IDLE; m_val = 0; m_pre = 0;
    end else if (bus.load) begin
      m_st = M_IDLE; m_val = preset_val(bus.load_val); m_pre = 0;
    end else begin
      case (m_st)
        M_IDLE: if (bus.start_stop) begin m_st = M_RUN; m_pre = 0; end
        M_RUN: begin
          if (m_pre == TDIV - 1) begin
            m_pre = 0;
            if ((bus.dir && m_val == 0) || (!bus.dir && m_val == 9999)) m_st = M_DONE;
            else m_val = bus.dir ? m_val - 1 : m_val + 1;
          end else begin
            m_pre = m_pre + 1;
          end
          if (m_st == M_RUN && bus.start_stop) m_st = M_PAUSE;
        end
        M_PAUSE: if (bus.start_stop) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge msclk);
    model_step();
    #1;
    chk_eq("value", dut_val(), m_val);
    chk_eq("running", int'(bus.running), int'(m_st == M_RUN));
    chk_eq("done", int'(bus.done), int'(m_st == M_DONE));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_ss();
    bus.start_stop = 1'b1; cycle(); bus.start_stop = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load_val = v; bus.load = 1'b1; cycle(); bus.load = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
  endtask

  initial begin
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_val   = '0;
    bus.dir        = 1'b0;

    // Reset state
    reset = 1'b1; cycle(); reset = 1'b0;
    chk_eq("rst_val", dut_val(), 0);
    chk_eq("rst_running", int'(bus.running), 0);
    chk_eq("rst_done", int'(bus.done), 0);

    // Up-count for 40 cycles
    bus.dir = 1'b0;
    pulse_ss();
    run(40);
    chk_eq("s1_val", dut_val(), 10);
    chk_eq("s1_running", int'(bus.running), 1);

    // Carry across three digits in one tick
    do_load(16'h0999);
    pulse_ss();
    run(3);
    chk_eq("s2_before", dut_val(), 999);
    run(1);
    chk_eq("s2_val", dut_val(), 1000);

    // Borrow across three digits
    do_load(16'h1000);
    bus.dir = 1'b1;
    pulse_ss();
    run(4);
    chk_eq("borrow_val", dut_val(), 999);

    // Down-count to zero and DONE
    do_load(16'h0002);
    pulse_ss();
    run(4);
    chk_eq("s3_step1", dut_val(), 1);
    run(4);
    chk_eq("s3_step2", dut_val(), 0);
    chk_eq("s3_notdone", int'(bus.done), 0);
    run(4);
    chk_eq("s3_hold", dut_val(), 0);
    chk_eq("s3_done", int'(bus.done), 1);
    pulse_ss();
    run(8);
    chk_eq("s3_ignore_ss", int'(bus.done), 1);
    chk_eq("s3_ignore_run", int'(bus.running), 0);

    // Terminal value on entry: DONE on the first tick, digits unchanged
    do_load(16'h9999);
    bus.dir = 1'b0;
    pulse_ss();
    run(3);
    chk_eq("term_notyet", int'(bus.done), 0);
    run(1);
    chk_eq("term_done", int'(bus.done), 1);
    chk_eq("term_val", dut_val(), 9999);

    // Pause / resume keeps prescaler phase
    do_clear();
    pulse_ss();
    run(5);
    pulse_ss();
    chk_eq("s4_paused", int'(bus.running), 0);
    run(20);
    chk_eq("s4_hold", dut_val(), 1);
    pulse_ss();
    chk_eq("s4_resumed", int'(bus.running), 1);
    run(1);
    chk_eq("s4_pre", dut_val(), 1);
    run(1);
    chk_eq("s4_step", dut_val(), 2);

    // clear and load together in RUN: clear wins
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 16'h1234;
    cycle();
    bus.clear = 1'b0; bus.load = 1'b0;
    chk_eq("s5_val", dut_val(), 0);
    chk_eq("s5_idle", int'(bus.running), 0);
    do_load(16'hAB3F);
    chk_eq("s5_clamp", dut_val(), 9939);

    // Reset overrides start_stop mid-RUN
    do_load(16'h0123);
    pulse_ss();
    run(2);
    reset = 1'b1; bus.start_stop = 1'b1;
    cycle();
    reset = 1'b0; bus.start_stop = 1'b0;
    chk_eq("s6_val", dut_val(), 0);
    chk_eq("s6_running", int'(bus.running), 0);
    run(6);
    chk_eq("s6_stay_idle", dut_val(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 399) == 0);
      bus.clear      = ($urandom_range(0, 149) == 0);
      bus.load       = ($urandom_range(0, 79) == 0);
      bus.load_val   = 16'($urandom);
      bus.start_stop = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
      cycle();
    end
    reset = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.start_stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
